// File: rtl/instr_line_cache.sv
// Fully associative instruction cache: single-cycle hits, self-managed line fills on a miss.
// Replacement fills the lowest invalid line first, then cycles round-robin through full lines.
module instr_line_cache #(
   parameter int DATAW    = 16,
   parameter int INW      = 512,
   parameter int ADDRW    = 32,
   parameter int NUMLINES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_en,
   input  logic [ADDRW-1:0] fetch_addr,
   input  logic             flush,
   output logic             valid_out,
   output logic [DATAW-1:0] data_out,
   output logic             stall,
   output logic             mem_req,
   output logic [ADDRW-1:0] mem_addr,
   input  logic             mem_valid,
   input  logic [INW-1:0]   mem_data
);

   localparam int WORDS = INW / DATAW;
   localparam int OFFW  = $clog2(INW / 8);
   localparam int BYTEW = $clog2(DATAW / 8);
   localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int RRW   = $clog2(NUMLINES);

   typedef enum logic {IDLE, MISS} state_t;

   state_t                state;
   logic [NUMLINES-1:0]   line_valid;
   logic [ADDRW-1:0]      line_tag  [NUMLINES];
   logic [INW-1:0]        line_data [NUMLINES];
   logic [RRW-1:0]        rr;
   logic [IDXW-1:0]       miss_idx;

   logic [ADDRW-1:0]      lookup_base;
   logic [IDXW-1:0]       lookup_idx;
   logic                  hit;
   logic [RRW-1:0]        hit_line;
   logic                  have_free;
   logic [RRW-1:0]        victim;

   // Word 0 sits at the MSBs, so shift the wanted word up to the top.
   function automatic logic [DATAW-1:0] pick_word(input logic [INW-1:0] line,
                                                  input logic [IDXW-1:0] idx);
      logic [INW-1:0] shifted;
      shifted   = line << (int'(idx) * DATAW);
      pick_word = shifted[INW-1 -: DATAW];
   endfunction

   assign lookup_base = {fetch_addr[ADDRW-1:OFFW], {OFFW{1'b0}}};
   assign lookup_idx  = IDXW'(fetch_addr[OFFW-1:0] >> BYTEW);
   assign stall       = (state == MISS);

   always_comb begin
      hit      = 1'b0;
      hit_line = '0;
      for (int i = 0; i < NUMLINES; i++) begin
         if (line_valid[i] && line_tag[i] == lookup_base) begin
            hit      = 1'b1;
            hit_line = RRW'(i);
         end
      end
   end

   // A fill that coincides with a flush lands in line 0, as if the cache were already empty.
   always_comb begin
      have_free = 1'b0;
      victim    = rr;
      for (int i = NUMLINES - 1; i >= 0; i--) begin
         if (!line_valid[i]) begin
            have_free = 1'b1;
            victim    = RRW'(i);
         end
      end
      if (flush) begin
         victim = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (state == MISS && mem_valid) begin
         line_data[victim] <= mem_data;
         line_tag[victim]  <= mem_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         line_valid <= '0;
         rr         <= '0;
         miss_idx   <= '0;
         valid_out  <= 1'b0;
         data_out   <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         if (flush) begin
            line_valid <= '0;
            rr         <= '0;
         end
         case (state)
            IDLE: begin
               if (fetch_en) begin
                  if (hit && !flush) begin
                     valid_out <= 1'b1;
                     data_out  <= pick_word(line_data[hit_line], lookup_idx);
                  end else begin
                     state     <= MISS;
                     miss_idx  <= lookup_idx;
                     mem_req   <= 1'b1;
                     mem_addr  <= lookup_base;
                     valid_out <= 1'b0;
                  end
               end else begin
                  valid_out <= 1'b0;
               end
            end
            MISS: begin
               if (mem_valid) begin
                  line_valid[victim] <= 1'b1;
                  if (!have_free && !flush) begin
                     rr <= rr + RRW'(1);
                  end
                  data_out  <= pick_word(mem_data, miss_idx);
                  valid_out <= 1'b1;
                  mem_req   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_line_cache.sv
// Self-checking bench for instr_line_cache: directed scenarios followed by randomized traffic
// compared against a FIFO-of-tags reference model of the cache contents.
module tb_instr_line_cache;

   logic          clk = 1'b0;
   logic          rst;
   logic          fetch_en;
   logic [31:0]   fetch_addr;
   logic          flush;
   logic          valid_out;
   logic [15:0]   data_out;
   logic          stall;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_valid;
   logic [511:0]  mem_data;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Reference model: resident tags kept oldest-first, plus the outstanding miss.
   logic [31:0] mq[$];
   bit          mMiss;
   logic [31:0] mBase;
   int          mIdx;
   logic        mVo;
   logic [15:0] mDo;
   logic [31:0] mMemAddr;

   instr_line_cache dut (
      .clk        (clk),
      .rst        (rst),
      .fetch_en   (fetch_en),
      .fetch_addr (fetch_addr),
      .flush      (flush),
      .valid_out  (valid_out),
      .data_out   (data_out),
      .stall      (stall),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] memWord(input logic [31:0] base, input int i);
      return 16'(base >> 4) + 16'(i) + {6'(base >> 6), 10'b0};
   endfunction

   function automatic logic [511:0] memLine(input logic [31:0] base);
      logic [511:0] line;
      for (int i = 0; i < 32; i++) line[511 - 16*i -: 16] = memWord(base, i);
      return line;
   endfunction

   function automatic bit inCache(input logic [31:0] base);
      foreach (mq[i]) if (mq[i] == base) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void modelReset();
      mq.delete();
      mMiss    = 1'b0;
      mBase    = '0;
      mIdx     = 0;
      mVo      = 1'b0;
      mDo      = '0;
      mMemAddr = '0;
   endfunction

   // Advance the model by one rising edge using the inputs presented at that edge.
   function automatic void modelEdge();
      logic [31:0] base;
      int          idx;
      if (!mMiss) begin
         if (flush) mq.delete();
         if (fetch_en) begin
            base = fetch_addr & ~32'h3F;
            idx  = int'((fetch_addr & 32'h3F) >> 1);
            if (inCache(base)) begin
               mVo = 1'b1;
               mDo = memWord(base, idx);
            end else begin
               mMiss    = 1'b1;
               mBase    = base;
               mIdx     = idx;
               mMemAddr = base;
               mVo      = 1'b0;
            end
         end else begin
            mVo = 1'b0;
         end
      end else begin
         if (flush) mq.delete();
         if (mem_valid) begin
            if (mq.size() == 4) void'(mq.pop_front());
            mq.push_back(mBase);
            mVo   = 1'b1;
            mDo   = memWord(mBase, mIdx);
            mMiss = 1'b0;
         end
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string step);
      checkOutput({step, ".valid_out"}, 32'(valid_out), 32'(mVo));
      checkOutput({step, ".data_out"},  32'(data_out),  32'(mDo));
      checkOutput({step, ".stall"},     32'(stall),     32'(mMiss));
      checkOutput({step, ".mem_req"},   32'(mem_req),   32'(mMiss));
      checkOutput({step, ".mem_addr"},  mem_addr,       mMemAddr);
   endtask

   task automatic applyStimulus(input string step, input logic en, input logic [31:0] addr,
                                input logic fl, input logic mv);
      fetch_en   = en;
      fetch_addr = addr;
      flush      = fl;
      mem_valid  = mv;
      mem_data   = (mv && mMiss) ? memLine(mBase) : {16{$urandom}};
      @(posedge clk);
      modelEdge();
      #1;
      checkAll(step);
   endtask

   task automatic doReset(input string step);
      rst = 1'b1;
      #1;
      modelReset();
      checkAll(step);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic fillLine(input string step, input logic [31:0] addr);
      applyStimulus(step, 1'b1, addr, 1'b0, 1'b0);
      applyStimulus(step, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   initial begin
      fetch_en   = 1'b0;
      fetch_addr = '0;
      flush      = 1'b0;
      mem_valid  = 1'b0;
      mem_data   = '0;
      modelReset();
      doReset("reset");

      // Cold miss, three-cycle fill, then a hit on the next word.
      applyStimulus("cold_req", 1'b1, 32'h1000, 1'b0, 1'b0);
      checkOutput("cold_mem_addr", mem_addr, 32'h1000);
      applyStimulus("cold_wait1", 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus("cold_wait2", 1'b0, 32'h0, 1'b0, 1'b0);
      applyStimulus("cold_fill", 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("cold_data", 32'(data_out), 32'h0100);
      applyStimulus("hit_1002", 1'b1, 32'h1002, 1'b0, 1'b0);
      checkOutput("hit_1002_data", 32'(data_out), 32'h0101);

      // Back-to-back hits at the last and first words of the line.
      applyStimulus("b2b_103e", 1'b1, 32'h103E, 1'b0, 1'b0);
      checkOutput("b2b_103e_data", 32'(data_out), 32'h011F);
      applyStimulus("b2b_1000", 1'b1, 32'h1000, 1'b0, 1'b0);
      checkOutput("b2b_1000_data", 32'(data_out), 32'h0100);

      // Round-robin replacement once all four lines are valid.
      doReset("rr_reset");
      fillLine("rr_fill0", 32'h000);
      fillLine("rr_fill1", 32'h040);
      fillLine("rr_fill2", 32'h080);
      fillLine("rr_fill3", 32'h0C0);
      fillLine("rr_fill4", 32'h100);
      applyStimulus("rr_miss0", 1'b1, 32'h000, 1'b0, 1'b0);
      checkOutput("rr_000_evicted", 32'(stall), 32'h1);
      applyStimulus("rr_refill0", 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus("rr_hit080", 1'b1, 32'h080, 1'b0, 1'b0);
      checkOutput("rr_080_kept", 32'(stall), 32'h0);
      applyStimulus("rr_miss040", 1'b1, 32'h040, 1'b0, 1'b0);
      checkOutput("rr_040_evicted", 32'(stall), 32'h1);
      applyStimulus("rr_refill040", 1'b0, 32'h0, 1'b0, 1'b1);

      // Flush alone, then flush together with a lookup of a resident line.
      applyStimulus("flush_pulse", 1'b0, 32'h0, 1'b1, 1'b0);
      applyStimulus("flush_miss", 1'b1, 32'h080, 1'b0, 1'b0);
      checkOutput("flush_mem_addr", mem_addr, 32'h080);
      applyStimulus("flush_fill", 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus("flush_same", 1'b1, 32'h080, 1'b1, 1'b0);
      checkOutput("flush_same_stall", 32'(stall), 32'h1);
      applyStimulus("flush_same_fill", 1'b0, 32'h0, 1'b0, 1'b1);

      // Idle mem_valid must be ignored.
      applyStimulus("idle_mv", 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus("idle_mv_hit", 1'b1, 32'h084, 1'b0, 1'b0);

      // Reset during an outstanding fill.
      applyStimulus("midrst_req", 1'b1, 32'h1800, 1'b0, 1'b0);
      applyStimulus("midrst_wait", 1'b0, 32'h0, 1'b0, 1'b0);
      doReset("midrst");
      applyStimulus("midrst_late_mv", 1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus("midrst_refetch", 1'b1, 32'h1800, 1'b0, 1'b0);
      checkOutput("midrst_refetch_stall", 32'(stall), 32'h1);
      applyStimulus("midrst_fill", 1'b0, 32'h0, 1'b0, 1'b1);

      // Randomized traffic over eight line addresses.
      for (int n = 0; n < 600; n++) begin
         logic        en;
         logic        fl;
         logic        mv;
         logic [31:0] addr;
         en   = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 24) == 0);
         mv   = mMiss ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         addr = 32'($urandom_range(0, 7) * 64 + $urandom_range(0, 63));
         applyStimulus("random", en, addr, fl, mv);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
